// File: rtl/vdu_mem_port.sv
// vdu_mem_port: display-memory responder for the VDU read port and the CPU req/ack port.
// It owns a single-port byte RAM (16x32 character screen). VDU reads have fixed one-cycle
// latency and top priority. CPU writes are posted through a small FIFO. CPU reads wait for
// a slot in which the FIFO is empty and the VDU is idle, so a read sees every earlier write.
// Optional feature: define VDU_MEM_STALL_CNT_EN to build the CPU stall-cycle counter.
// INIT_F names a hex image for the RAM. The image is attached by the implementation flow;
// this RTL has no simulation-only preload.
module vdu_mem_port #(
  parameter logic [15:0] BASE_ADDR  = 16'h0000,
  parameter int          DEPTH      = 512,
  parameter int          WBUF_DEPTH = 4,
  parameter              INIT_F     = ""
) (
  input  logic        clk_pix,
  input  logic        rst_pix,
  input  logic        read_en,
  input  logic [15:0] read_addr,
  output logic [7:0]  display_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        wbuf_full,
  output logic [15:0] stall_count
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          PW      = $clog2(WBUF_DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [16:0] DEPTH17 = 17'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, ACK} state_t;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [7:0]    data;
  } wr_t;

  logic [7:0]    mem  [DEPTH];
  wr_t           fifo [WBUF_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  state_t        state, state_nxt;

  logic [15:0]   vdu_off, cpu_off;
  logic          vdu_in, cpu_in;
  logic [AW-1:0] vdu_idx, cpu_idx;
  logic          fifo_full, fifo_empty;
  logic          push, drain, cpu_issue, rd_oow;
  logic [7:0]    rd_q;

  // Window decode: subtraction wraps, so addresses below BASE_ADDR land far above DEPTH.
  assign vdu_off    = read_addr - BASE_ADDR;
  assign cpu_off    = cpu_addr - BASE_ADDR;
  assign vdu_in     = ({1'b0, vdu_off} < DEPTH17);
  assign cpu_in     = ({1'b0, cpu_off} < DEPTH17);
  assign vdu_idx    = vdu_off[AW-1:0];
  assign cpu_idx    = cpu_off[AW-1:0];

  assign fifo_full  = (count == CW'(WBUF_DEPTH));
  assign fifo_empty = (count == '0);
  // The FIFO head takes the RAM slot whenever the VDU leaves it free.
  assign drain      = !fifo_empty && !read_en;
  assign count_nxt  = count + CW'(push) - CW'(drain);
  assign cpu_ack    = (state == ACK);

  // CPU transaction FSM: next state and per-cycle strobes.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    cpu_issue = 1'b0;
    rd_oow    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (!cpu_we) begin
            state_nxt = RD_WAIT;
          end else if (!fifo_full) begin
            // Out-of-window writes are acked but never reach the FIFO.
            push      = cpu_in;
            state_nxt = ACK;
          end
        end
      end
      RD_WAIT: begin
        if (!cpu_in) begin
          rd_oow    = 1'b1;
          state_nxt = ACK;
        end else if (fifo_empty && !read_en) begin
          cpu_issue = 1'b1;
          state_nxt = RD_DONE;
        end
      end
      RD_DONE: state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, FIFO pointers and registered outputs.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state        <= IDLE;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      wbuf_full    <= 1'b0;
      display_data <= 8'h00;
      cpu_rdata    <= 8'h00;
      rd_q         <= 8'h00;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      wbuf_full <= (count_nxt == CW'(WBUF_DEPTH));
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (drain) rd_ptr <= rd_ptr + PW'(1);
      if (read_en) display_data <= vdu_in ? mem[vdu_idx] : 8'h00;
      if (cpu_issue) rd_q <= mem[cpu_idx];
      if (rd_oow)                  cpu_rdata <= 8'hFF;
      else if (state == RD_DONE)   cpu_rdata <= rd_q;
    end
  end

  // Storage: FIFO entries and the RAM write port; contents survive reset.
  always_ff @(posedge clk_pix) begin
    if (push)  fifo[wr_ptr] <= '{idx: cpu_idx, data: cpu_wdata};
    if (drain) mem[fifo[rd_ptr].idx] <= fifo[rd_ptr].data;
  end

`ifdef VDU_MEM_STALL_CNT_EN
  logic        stall;
  logic [15:0] stall_q;

  assign stall = ((state == RD_WAIT) && cpu_in && !(fifo_empty && !read_en)) ||
                 ((state == IDLE) && cpu_req && cpu_we && fifo_full);

  // Saturating count of cycles the CPU port is held off.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix)                          stall_q <= 16'h0000;
    else if (stall && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_vdu_mem_port.sv
// Bench for vdu_mem_port: transaction-level model (RAM array + write queue + ack schedule),
// one per-cycle compare process, directed scenarios with literal expectations, random traffic.
module tb_vdu_mem_port;
  localparam int          DEPTH = 512;
  localparam int          WB    = 4;
  localparam logic [15:0] BASE  = 16'h0100;

  logic        clk_pix = 1'b0;
  logic        rst_pix = 1'b1;
  logic        read_en = 1'b0;
  logic [15:0] read_addr = '0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  display_data, cpu_rdata;
  logic        cpu_ack, wbuf_full;
  logic [15:0] stall_count;

  vdu_mem_port #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WBUF_DEPTH(WB)) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .read_en(read_en), .read_addr(read_addr),
    .display_data(display_data), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .wbuf_full(wbuf_full),
    .stall_count(stall_count));

  always #5 clk_pix = ~clk_pix;

  int n_tests = 0, n_fail = 0;

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct { int off; logic [7:0] d; } wr_t;
  logic [7:0] m_ram [DEPTH];
  bit         m_known [DEPTH];
  wr_t        m_q [$];
  bit         m_busy, m_rd_wait, m_rdata_known;
  logic [15:0] m_raddr;
  logic [7:0] m_rdata;
  longint     m_ack_at, cyc = 0;
  logic [7:0] e_disp = 8'h00;
  bit         e_disp_known = 1'b1, e_ack = 1'b0, e_full = 1'b0;
  int         e_stall = 0;
  bit         chk_en = 1'b0, rand_vdu = 1'b0;
  int         vdu_pct = 0;

  function automatic bit inwin(logic [15:0] a);
    logic [15:0] o;
    o = a - BASE;
    return int'(o) < DEPTH;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_busy = 0; m_rd_wait = 0;
    e_disp = 8'h00; e_disp_known = 1; e_ack = 0; e_full = 0; e_stall = 0;
  endtask

  // Advance the model over one clock cycle using the inputs presented during it.
  task automatic model_step();
    logic [15:0] o;
    wr_t w, h;
    bit stall, do_push;
    int qn;
    stall = 0; do_push = 0; qn = m_q.size();
    if (read_en) begin
      if (inwin(read_addr)) begin
        o = read_addr - BASE;
        e_disp = m_ram[int'(o)]; e_disp_known = m_known[int'(o)];
      end else begin
        e_disp = 8'h00; e_disp_known = 1;
      end
    end
    if (m_busy) begin
      if (m_rd_wait) begin
        if (!inwin(m_raddr)) begin
          m_rdata = 8'hFF; m_rdata_known = 1; m_ack_at = cyc + 1; m_rd_wait = 0;
        end else if (qn == 0 && !read_en) begin
          o = m_raddr - BASE;
          m_rdata = m_ram[int'(o)]; m_rdata_known = m_known[int'(o)];
          m_ack_at = cyc + 2; m_rd_wait = 0;
        end else stall = 1;
      end else if (cyc == m_ack_at) m_busy = 0;
    end else if (cpu_req) begin
      if (!cpu_we) begin
        m_busy = 1; m_rd_wait = 1; m_raddr = cpu_addr;
      end else if (qn == WB) stall = 1;
      else begin
        m_busy = 1; m_ack_at = cyc + 1;
        if (inwin(cpu_addr)) begin
          o = cpu_addr - BASE; w.off = int'(o); w.d = cpu_wdata; do_push = 1;
        end
      end
    end
    if (qn > 0 && !read_en) begin
      h = m_q.pop_front(); m_ram[h.off] = h.d; m_known[h.off] = 1;
    end
    if (do_push) m_q.push_back(w);
    if (stall && e_stall < 65535) e_stall++;
    cyc++;
    e_ack  = m_busy && !m_rd_wait && (m_ack_at == cyc);
    e_full = (m_q.size() == WB);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_pix) begin
    if (chk_en) begin
      if (e_disp_known) chk("display_data", display_data, e_disp);
      chk("cpu_ack", cpu_ack, e_ack);
      if (e_ack && m_rdata_known) chk("cpu_rdata", cpu_rdata, m_rdata);
      chk("wbuf_full", wbuf_full, e_full);
`ifdef VDU_MEM_STALL_CNT_EN
      chk("stall_count", stall_count, e_stall);
`else
      chk("stall_count", stall_count, 0);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [15:0] rnd_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 16'($urandom_range(0, 65535));
    if (r == 1) return BASE + 16'(DEPTH);
    if (r == 2) return BASE - 16'd1;
    if (r == 3) return BASE + 16'(DEPTH - 1);
    return BASE + 16'($urandom_range(0, 63));
  endfunction

  task automatic tick();
    @(posedge clk_pix);
    if (!rst_pix) model_step();
    #1;
    if (rand_vdu) begin
      read_en   = ($urandom_range(0, 99) < vdu_pct);
      read_addr = rnd_addr();
    end
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (e_ack) begin lat = i; break; end
    end
    if (lat == 0) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout: no ack within 400 cycles at t=%0t", $time);
    end
  endtask

  task automatic cpu_op(input bit we, input logic [15:0] a, input logic [7:0] d, output int lat);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    wait_ack(lat);
    cpu_req = 0; cpu_we = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    idle(3);
    chk("rst_display", display_data, 8'h00);
    chk("rst_ack", cpu_ack, 0);
    chk("rst_rdata", cpu_rdata, 8'h00);
    chk("rst_full", wbuf_full, 0);
    chk("rst_stall", stall_count, 0);
    rst_pix = 0; model_reset(); chk_en = 1;
    idle(1);

    // Write then VDU read-back.
    cpu_op(1, BASE + 16'd5, 8'h41, lat);
    chk("t2_write_lat", lat, 1);
    chk("t2_dut_ack", cpu_ack, 1);
    idle(1);
    read_en = 1; read_addr = BASE + 16'd5; tick(); read_en = 0;
    chk("t2_display", display_data, 8'h41);
    chk("t2_model_display", e_disp, 8'h41);

    // Window boundaries.
    cpu_op(1, BASE, 8'h3C, lat); idle(2);
    read_en = 1; read_addr = BASE + 16'(DEPTH); tick(); read_en = 0;
    chk("t5_oow_display", display_data, 8'h00);
    idle(1);
    cpu_op(0, BASE - 16'd1, 8'h00, lat);
    chk("t5_oow_read_lat", lat, 2);
    chk("t5_oow_rdata", cpu_rdata, 8'hFF);
    idle(1);
    cpu_op(1, BASE + 16'(DEPTH), 8'h99, lat);
    chk("t5_oow_write_lat", lat, 1);
    idle(2);
    read_en = 1; read_addr = BASE; tick(); read_en = 0;
    chk("t5_ram_unchanged", display_data, 8'h3C);
    idle(1);

    // Read-after-write goes through the FIFO ordering.
    cpu_op(1, BASE + 16'd10, 8'h7E, lat);
    cpu_op(0, BASE + 16'd10, 8'h00, lat);
    chk("t4_raw_rdata", cpu_rdata, 8'h7E);
    idle(1);
    cpu_op(0, BASE + 16'd11, 8'h00, lat);
    idle(2);

    // FIFO fill under continuous VDU reads, then drain.
    read_en = 1; read_addr = BASE;
    for (int i = 0; i < 4; i++) cpu_op(1, BASE + 16'(30 + i), 8'(8'hA0 + i), lat);
    chk("t3_full", wbuf_full, 1);
    cpu_req = 1; cpu_we = 1; cpu_addr = BASE + 16'd34; cpu_wdata = 8'hA4;
    for (int i = 0; i < 4; i++) begin tick(); chk("t3_no_ack", cpu_ack, 0); end
    read_en = 0;
    wait_ack(lat);
    cpu_req = 0; cpu_we = 0;
    chk("t3_drain_lat", lat, 2);
    chk("t3_not_full", wbuf_full, 0);
    idle(6);
    read_en = 1; read_addr = BASE + 16'd34; tick(); read_en = 0;
    chk("t3_fifth_landed", display_data, 8'hA4);

    // Async reset while a read is parked in RD_WAIT.
    read_en = 1; read_addr = BASE + 16'd5; tick();
    for (int i = 0; i < 4; i++) cpu_op(1, BASE + 16'(40 + i), 8'h55, lat);
    cpu_req = 1; cpu_we = 0; cpu_addr = BASE + 16'd5;
    idle(3);
    chk("t1_full_before", wbuf_full, 1);
    chk("t1_disp_before", display_data, 8'h41);
    #1 rst_pix = 1; model_reset();
    #1;
    chk("t1_rst_ack", cpu_ack, 0);
    chk("t1_rst_display", display_data, 8'h00);
    chk("t1_rst_full", wbuf_full, 0);
    cpu_req = 0; read_en = 0;
    idle(2);
    rst_pix = 0;
    idle(1);
    cpu_op(1, BASE + 16'd50, 8'h12, lat);
    chk("t1_idle_after_rst", lat, 1);
    idle(3);

    // Stall counter: ten blocked RD_WAIT cycles.
    read_en = 1; read_addr = BASE + 16'd7;
    cpu_req = 1; cpu_we = 0; cpu_addr = BASE + 16'd5;
    idle(11);
`ifdef VDU_MEM_STALL_CNT_EN
    chk("t6_stall10", stall_count, 10);
    chk("t6_model_stall10", e_stall, 10);
`else
    chk("t6_stall0", stall_count, 0);
`endif
    read_en = 0;
    wait_ack(lat);
    cpu_req = 0;
    chk("t6_rdata", cpu_rdata, 8'h41);
    idle(2);

    // Random traffic.
    rand_vdu = 1;
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) vdu_pct = $urandom_range(0, 70);
      cpu_op($urandom_range(0, 1) == 1, rnd_addr(), 8'($urandom_range(0, 255)), lat);
      idle($urandom_range(0, 2));
    end
    rand_vdu = 0; read_en = 0;
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
